shift_seq_arb: RTL

Iterative 16-bit shift/rotate engine shared between two requesters.
- A round-robin arbiter grants one request at a time.
- The granted operand is captured into an internal register, then shifted over four cycles, one power-of-two stage per cycle (1, 2, 4, 8).
- The result is returned on a valid/ready response port.
- Used where area matters more than latency, in place of a full single-cycle 4-level barrel shifter.

---
 rtl/shift_seq_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_seq_arb.sv
// rtl/shift_seq_arb.sv - two-requester round-robin arbitrated iterative 16-bit shift/rotate engine
module shift_seq_arb #(
    parameter logic RR_RESET_PTR = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_in,
    input  logic [3:0]  req0_cnt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_in,
    input  logic [3:0]  req1_cnt,
    input  logic [1:0]  req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_out,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_ROL = 2'd0;
    localparam logic [1:0] OP_SLL = 2'd1;
    localparam logic [1:0] OP_ROR = 2'd2;

    logic [1:0]  state;
    logic [1:0]  k;
    logic [15:0] data_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic        id_q;
    logic        ptr;

    logic        grant_any;
    logic        grant_id;
    logic [3:0]  amt;

    // Rotations use a doubled operand so the wrapped bits fall into the kept half.
    function automatic logic [15:0] shift_step(input logic [15:0] d,
                                               input logic [1:0]  op,
                                               input logic [3:0]  s);
        logic [31:0] dd;
        logic [15:0] r;
        dd = {d, d};
        case (op)
            OP_ROL: begin
                dd = dd << s;
                r  = dd[31:16];
            end
            OP_SLL: r = d << s;
            OP_ROR: begin
                dd = dd >> s;
                r  = dd[15:0];
            end
            default: r = $signed(d) >>> s;
        endcase
        return r;
    endfunction

    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = (req0_valid & req1_valid) ? ptr : req1_valid;
    end

    assign req0_ready = (state == S_IDLE) & req0_valid & ~grant_id;
    assign req1_ready = (state == S_IDLE) & req1_valid & grant_id;
    assign amt        = 4'b0001 << k;

    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign resp_out   = data_q;
    assign resp_id    = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            k      <= 2'd0;
            data_q <= 16'h0000;
            cnt_q  <= 4'd0;
            op_q   <= 2'd0;
            id_q   <= 1'b0;
            ptr    <= RR_RESET_PTR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        data_q <= grant_id ? req1_in  : req0_in;
                        cnt_q  <= grant_id ? req1_cnt : req0_cnt;
                        op_q   <= grant_id ? req1_op  : req0_op;
                        id_q   <= grant_id;
                        ptr    <= ~grant_id;
                        k      <= 2'd0;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Stage k contributes 2^k positions only when its count bit is set.
                    if (cnt_q[k]) begin
                        data_q <= shift_step(data_q, op_q, amt);
                    end
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
